// File: rtl/pe_compute_seq.sv
// Sequential PE compute unit: valid/ready handshaked ALU with iterative divide and square root.
// Optional build macro SATURATE_EN: signed saturation for ADD/SUB/MUL/MAC plus a sat_flag output.
module pe_compute_seq #(
    parameter int dataLen  = 32,
    parameter int logNumFn = 3,
    parameter int peId     = 0,
    parameter int puId     = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [logNumFn-1:0] fn,
    input  logic [dataLen-1:0]  operand1,
    input  logic [dataLen-1:0]  operand2,
    input  logic [dataLen-1:0]  operand3,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [dataLen-1:0]  resultOut,
    output logic                eol_flag,
`ifdef SATURATE_EN
    output logic                sat_flag,
`endif
    output logic                div_zero
);

    localparam int HalfLen = dataLen / 2;
    localparam int CntW    = $clog2(dataLen);
    localparam int RemW    = HalfLen + 2;

    localparam logic [logNumFn-1:0] FnPass = logNumFn'(0);
    localparam logic [logNumFn-1:0] FnAdd  = logNumFn'(1);
    localparam logic [logNumFn-1:0] FnSub  = logNumFn'(2);
    localparam logic [logNumFn-1:0] FnMul  = logNumFn'(3);
    localparam logic [logNumFn-1:0] FnMac  = logNumFn'(4);
    localparam logic [logNumFn-1:0] FnDiv  = logNumFn'(5);
    localparam logic [logNumFn-1:0] FnSqr  = logNumFn'(6);

    localparam logic [CntW-1:0] DivLast = CntW'(dataLen - 1);
    localparam logic [CntW-1:0] SqrLast = CntW'(HalfLen - 1);

    if (dataLen < 8 || (dataLen % 2) != 0 || logNumFn < 3 || peId < 0 || puId < 0) begin : gBadParams
        $error("pe_compute_seq: unsupported parameter set");
    end

    typedef enum logic [1:0] {IDLE, BUSY, HOLD} stateT;

    stateT state;
    stateT nextState;

    logic accept;
    logic needsIter;
    logic lastIter;

    logic [CntW-1:0]    iterCnt;
    logic               iterSqr;
    logic [dataLen-1:0] divisor;
    logic [dataLen-1:0] divRem;
    // Holds the shifting quotient for DIV and the shifting radicand for SQR.
    logic [dataLen-1:0] work;
    logic [RemW-1:0]    sqRem;
    logic [HalfLen-1:0] sqRoot;

    logic [dataLen:0]   divShift;
    logic [dataLen-1:0] divRemNext;
    logic [dataLen-1:0] quoNext;
    logic [RemW-1:0]    sqShift;
    logic [RemW-1:0]    sqRemNext;
    logic [HalfLen-1:0] sqRootNext;

    logic [dataLen-1:0] fastRes;
    logic               fastEol;
    logic               fastDz;

`ifdef SATURATE_EN
    localparam logic [dataLen-1:0] SatMax = {1'b0, {(dataLen-1){1'b1}}};
    localparam logic [dataLen-1:0] SatMin = {1'b1, {(dataLen-1){1'b0}}};

    logic                        fastSat;
    logic signed [2*dataLen-1:0] mulFull;
    logic [2*dataLen:0]          macFull;
    logic                        mulOvf;
    logic                        macOvf;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic
    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (accept) nextState = needsIter ? BUSY : HOLD;
            end
            BUSY: begin
                if (lastIter) nextState = HOLD;
            end
            HOLD: begin
                if (accept)         nextState = needsIter ? BUSY : HOLD;
                else if (out_ready) nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    // Handshake outputs
    always_comb begin
        in_ready  = (state == IDLE) || ((state == HOLD) && out_ready);
        out_valid = (state == HOLD);
        accept    = in_valid && in_ready;
    end

    always_comb begin
        needsIter = (fn == FnSqr) || ((fn == FnDiv) && (operand2 != '0));
        lastIter  = (iterCnt == (iterSqr ? SqrLast : DivLast));
    end

    // One restoring-divide step and one non-restoring square-root step.
    always_comb begin
        divShift = {divRem, work[dataLen-1]};
        if (divShift >= {1'b0, divisor}) begin
            divRemNext = dataLen'(divShift - {1'b0, divisor});
            quoNext    = {work[dataLen-2:0], 1'b1};
        end else begin
            divRemNext = divShift[dataLen-1:0];
            quoNext    = {work[dataLen-2:0], 1'b0};
        end

        // The remainder is kept modulo 2^RemW; its true value always fits, so the sign bit is exact.
        sqShift = {sqRem[RemW-3:0], work[dataLen-1 -: 2]};
        if (sqRem[RemW-1]) begin
            sqRemNext = sqShift + {sqRoot, 2'b11};
        end else begin
            sqRemNext = sqShift - {sqRoot, 2'b01};
        end
        sqRootNext = {sqRoot[HalfLen-2:0], ~sqRemNext[RemW-1]};
    end

`ifdef SATURATE_EN
    always_comb begin
        mulFull = $signed(operand1) * $signed(operand2);
        macFull = {mulFull[2*dataLen-1], mulFull} + {{(dataLen+1){operand3[dataLen-1]}}, operand3};
        mulOvf  = !((&mulFull[2*dataLen-1:dataLen-1]) || !(|mulFull[2*dataLen-1:dataLen-1]));
        macOvf  = !((&macFull[2*dataLen:dataLen-1]) || !(|macFull[2*dataLen:dataLen-1]));
    end
`endif

    // Single-cycle result
    always_comb begin
        fastRes = '0;
        fastDz  = 1'b0;
`ifdef SATURATE_EN
        fastSat = 1'b0;
`endif
        case (fn)
            FnPass: fastRes = operand1;
            FnAdd: begin
                fastRes = operand1 + operand2;
`ifdef SATURATE_EN
                if ((operand1[dataLen-1] == operand2[dataLen-1]) &&
                    (fastRes[dataLen-1] != operand1[dataLen-1])) begin
                    fastRes = operand1[dataLen-1] ? SatMin : SatMax;
                    fastSat = 1'b1;
                end
`endif
            end
            FnSub: begin
                fastRes = operand1 - operand2;
`ifdef SATURATE_EN
                if ((operand1[dataLen-1] != operand2[dataLen-1]) &&
                    (fastRes[dataLen-1] != operand1[dataLen-1])) begin
                    fastRes = operand1[dataLen-1] ? SatMin : SatMax;
                    fastSat = 1'b1;
                end
`endif
            end
            FnMul: begin
`ifdef SATURATE_EN
                fastRes = mulOvf ? (mulFull[2*dataLen-1] ? SatMin : SatMax) : mulFull[dataLen-1:0];
                fastSat = mulOvf;
`else
                fastRes = operand1 * operand2;
`endif
            end
            FnMac: begin
`ifdef SATURATE_EN
                fastRes = macOvf ? (macFull[2*dataLen] ? SatMin : SatMax) : macFull[dataLen-1:0];
                fastSat = macOvf;
`else
                fastRes = operand1 * operand2 + operand3;
`endif
            end
            FnDiv: begin
                // Only reaches HOLD directly when the divisor is zero.
                fastRes = '1;
                fastDz  = 1'b1;
            end
            default: fastRes = '0;
        endcase
        fastEol = (fn == FnSub) && (fastRes == '0);
    end

    // Datapath and registered results
    always_ff @(posedge clk) begin
        if (reset) begin
            resultOut <= '0;
            eol_flag  <= 1'b0;
            div_zero  <= 1'b0;
`ifdef SATURATE_EN
            sat_flag  <= 1'b0;
`endif
            iterCnt   <= '0;
            iterSqr   <= 1'b0;
            divisor   <= '0;
            divRem    <= '0;
            work      <= '0;
            sqRem     <= '0;
            sqRoot    <= '0;
        end else if (accept) begin
            iterCnt <= '0;
            if (needsIter) begin
                iterSqr <= (fn == FnSqr);
                divisor <= operand2;
                work    <= operand1;
                divRem  <= '0;
                sqRem   <= '0;
                sqRoot  <= '0;
            end else begin
                resultOut <= fastRes;
                eol_flag  <= fastEol;
                div_zero  <= fastDz;
`ifdef SATURATE_EN
                sat_flag  <= fastSat;
`endif
            end
        end else if (state == BUSY) begin
            iterCnt <= iterCnt + 1'b1;
            if (iterSqr) begin
                sqRem  <= sqRemNext;
                sqRoot <= sqRootNext;
                work   <= {work[dataLen-3:0], 2'b00};
            end else begin
                divRem <= divRemNext;
                work   <= quoNext;
            end
            if (lastIter) begin
                resultOut <= iterSqr ? {{HalfLen{1'b0}}, sqRootNext} : quoNext;
                eol_flag  <= 1'b0;
                div_zero  <= 1'b0;
`ifdef SATURATE_EN
                sat_flag  <= 1'b0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_pe_compute_seq.sv
// Self-checking bench for pe_compute_seq: directed literal cases plus randomized traffic
// checked every cycle against a latency/result model. Honours SATURATE_EN when defined.
module tb_pe_compute_seq;

    localparam int DL = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [2:0]    fn = '0;
    logic [DL-1:0] op1 = '0;
    logic [DL-1:0] op2 = '0;
    logic [DL-1:0] op3 = '0;
    logic          in_ready;
    logic          out_valid;
    logic [DL-1:0] resultOut;
    logic          eolFlag;
    logic          divZero;
`ifdef SATURATE_EN
    logic          satFlag;
`endif

    int errors = 0;
    int checks = 0;
    bit checkEn = 1'b0;

    always #5 clk = ~clk;

    pe_compute_seq #(.dataLen(DL), .logNumFn(3), .peId(1), .puId(2)) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .fn(fn),
        .operand1(op1),
        .operand2(op2),
        .operand3(op3),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .resultOut(resultOut),
        .eol_flag(eolFlag),
`ifdef SATURATE_EN
        .sat_flag(satFlag),
`endif
        .div_zero(divZero)
    );

    task automatic chk(input string name, input logic [DL-1:0] act, input logic [DL-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: result, flags and accept-to-valid latency from the function definitions.
    task automatic refOp(input logic [2:0] f, input logic [DL-1:0] a, input logic [DL-1:0] b,
                         input logic [DL-1:0] c, output logic [DL-1:0] r, output bit eol,
                         output bit dz, output bit sat, output int lat);
        longint sa, sb, sc, full, root, t;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sc = longint'($signed(c));
        full = 0;
        r = '0; dz = 1'b0; sat = 1'b0; lat = 1;
        case (f)
            3'd0: r = a;
            3'd1, 3'd2, 3'd3, 3'd4: begin
                if (f == 3'd1)      full = sa + sb;
                else if (f == 3'd2) full = sa - sb;
                else if (f == 3'd3) full = sa * sb;
                else                full = sa * sb + sc;
                r = full[DL-1:0];
`ifdef SATURATE_EN
                if (full > 64'sd2147483647)       begin r = 32'h7FFF_FFFF; sat = 1'b1; end
                else if (full < -64'sd2147483648) begin r = 32'h8000_0000; sat = 1'b1; end
`endif
            end
            3'd5: begin
                if (b == '0) begin r = '1; dz = 1'b1; end
                else begin r = a / b; lat = DL + 1; end
            end
            3'd6: begin
                root = 0;
                for (int i = DL/2 - 1; i >= 0; i--) begin
                    t = root | (64'sd1 <<< i);
                    if (t * t <= longint'({32'd0, a})) root = t;
                end
                r = root[DL-1:0];
                lat = DL/2 + 1;
            end
            default: r = '0;
        endcase
        eol = (f == 3'd2) && (r == '0);
    endtask

    // Model state: remaining busy cycles, presence of a held result, and visible outputs.
    int            mBusy = 0;
    bit            mHold = 1'b0;
    logic [DL-1:0] mRes = '0;
    logic [DL-1:0] pRes = '0;
    bit            mEol, mDz, mSat, pEol, pDz, pSat;

    always @(negedge clk) begin
        bit            expReady, acc, e, d, s;
        logic [DL-1:0] r;
        int            lat;
        expReady = (mBusy == 0) && (!mHold || out_ready);
        if (checkEn) begin
            chk("m_in_ready", {31'd0, in_ready}, {31'd0, expReady});
            chk("m_out_valid", {31'd0, out_valid}, {31'd0, mHold});
            if (mBusy == 0) chk("m_result", resultOut, mRes);
            chk("m_eol", {31'd0, eolFlag}, {31'd0, mEol});
            chk("m_divzero", {31'd0, divZero}, {31'd0, mDz});
`ifdef SATURATE_EN
            chk("m_sat", {31'd0, satFlag}, {31'd0, mSat});
`endif
        end
        if (reset) begin
            mBusy = 0; mHold = 1'b0; mRes = '0;
            mEol = 1'b0; mDz = 1'b0; mSat = 1'b0;
        end else begin
            acc = in_valid && expReady;
            if (mBusy > 0) begin
                mBusy--;
                if (mBusy == 0) begin
                    mHold = 1'b1; mRes = pRes; mEol = pEol; mDz = pDz; mSat = pSat;
                end
            end else if (mHold && out_ready) begin
                mHold = 1'b0;
            end
            if (acc) begin
                refOp(fn, op1, op2, op3, r, e, d, s, lat);
                if (lat == 1) begin
                    mHold = 1'b1; mRes = r; mEol = e; mDz = d; mSat = s;
                end else begin
                    mHold = 1'b0; mBusy = lat - 1; pRes = r; pEol = e; pDz = d; pSat = s;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] f, input logic [DL-1:0] a, input logic [DL-1:0] b,
                         input logic [DL-1:0] c);
        in_valid = 1'b1; fn = f; op1 = a; op2 = b; op3 = c;
    endtask

    function automatic logic [DL-1:0] pickOp();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return 32'd1;
            2: return '1;
            3: return 32'h7FFF_FFFF;
            4: return 32'h8000_0000;
            5: return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        bit lastAcc;
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        out_ready = 1'b1;
        checkEn = 1'b1;
        chk("d_reset_in_ready", {31'd0, in_ready}, 32'd1);
        chk("d_reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("d_reset_result", resultOut, 32'd0);

        drive(3'd1, 32'd5, 32'd7, 32'd0);
        step();
        in_valid = 1'b0;
        chk("d_add_valid", {31'd0, out_valid}, 32'd1);
        chk("d_add_result", resultOut, 32'd12);
        chk("d_add_eol", {31'd0, eolFlag}, 32'd0);
        chk("d_add_in_ready", {31'd0, in_ready}, 32'd1);

        drive(3'd2, 32'd9, 32'd9, 32'd0);
        step();
        chk("d_sub0_result", resultOut, 32'd0);
        chk("d_sub0_eol", {31'd0, eolFlag}, 32'd1);
        drive(3'd2, 32'd3, 32'd1, 32'd0);
        step();
        in_valid = 1'b0;
        chk("d_sub1_valid", {31'd0, out_valid}, 32'd1);
        chk("d_sub1_result", resultOut, 32'd2);
        chk("d_sub1_eol", {31'd0, eolFlag}, 32'd0);
        step();
        chk("d_idle_valid", {31'd0, out_valid}, 32'd0);

        drive(3'd5, 32'd100, 32'd7, 32'd0);
        step();
        in_valid = 1'b0;
        for (int i = 0; i < DL; i++) begin
            chk("d_div_busy", {31'd0, in_ready}, 32'd0);
            step();
        end
        chk("d_div_valid", {31'd0, out_valid}, 32'd1);
        chk("d_div_result", resultOut, 32'd14);
        drive(3'd5, 32'd123, 32'd0, 32'd0);
        step();
        in_valid = 1'b0;
        chk("d_div0_result", resultOut, 32'hFFFF_FFFF);
        chk("d_div0_flag", {31'd0, divZero}, 32'd1);
        step();

        out_ready = 1'b0;
        drive(3'd6, 32'd1000, 32'd0, 32'd0);
        step();
        in_valid = 1'b0;
        for (int i = 0; i < DL/2; i++) begin
            chk("d_sqr_busy", {31'd0, out_valid}, 32'd0);
            step();
        end
        for (int i = 0; i < 5; i++) begin
            chk("d_sqr_hold_valid", {31'd0, out_valid}, 32'd1);
            chk("d_sqr_hold_result", resultOut, 32'd31);
            step();
        end
        out_ready = 1'b1;
        step();
        chk("d_sqr_release", {31'd0, out_valid}, 32'd0);
        chk("d_sqr_idle_result", resultOut, 32'd31);

        drive(3'd5, 32'd1000, 32'd3, 32'd0);
        step();
        in_valid = 1'b0;
        repeat (9) step();
        reset = 1'b1;
        step();
        chk("d_abort_valid", {31'd0, out_valid}, 32'd0);
        chk("d_abort_result", resultOut, 32'd0);
        reset = 1'b0;
        chk("d_abort_in_ready", {31'd0, in_ready}, 32'd1);
        drive(3'd1, 32'd1, 32'd1, 32'd0);
        step();
        in_valid = 1'b0;
        chk("d_after_abort", resultOut, 32'd2);

        drive(3'd1, 32'h7FFF_FFFF, 32'd1, 32'd0);
        step();
        in_valid = 1'b0;
`ifdef SATURATE_EN
        chk("d_sat_result", resultOut, 32'h7FFF_FFFF);
        chk("d_sat_flag", {31'd0, satFlag}, 32'd1);
`else
        chk("d_wrap_result", resultOut, 32'h8000_0000);
`endif
        step();

        lastAcc = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            reset = ($urandom_range(0, 299) == 0);
            if (!in_valid || lastAcc) begin
                in_valid = ($urandom_range(0, 2) != 0);
                fn  = 3'($urandom_range(0, 7));
                op1 = pickOp();
                op2 = pickOp();
                op3 = pickOp();
            end
            @(negedge clk);
            lastAcc = (in_valid && in_ready) || reset;
            @(posedge clk);
            #1;
        end

        reset = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (3) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

endmodule
